// File: rtl/pc_run_monitor.sv
// Watches the core PC: counts RUN cycles, keeps a circular trace of distinct PCs, flags halts.
// Trace reads return one cycle after rd_idx is presented; there is no backpressure, and run_en=0 freezes all state.
module pc_run_monitor #(
   parameter int ADDR_W        = 8,
   parameter int DEPTH         = 16,
   parameter int CNT_W         = 32,
   parameter int HALT_CYCLES   = 4,
   parameter int USE_HALT_ADDR = 0,
   parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'('hFC)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        pc,
   input  logic                     run_en,
   input  logic                     clr,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [ADDR_W-1:0]        rd_data,
   output logic                     rd_hit,
   output logic [$clog2(DEPTH):0]   trace_count,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic                     halted,
   output logic [ADDR_W-1:0]        halt_pc,
   output logic [1:0]               state
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(HALT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t              cur_st, nxt_st;
   logic [ADDR_W-1:0]   trace_mem [DEPTH];
   logic [PW-1:0]       wptr, nxt_wptr;
   logic [ADDR_W-1:0]   prev_pc, nxt_prev;
   logic [SW-1:0]       stall_cnt, nxt_stall;
   logic [PW:0]         nxt_tc;
   logic [CNT_W-1:0]    nxt_cnt;
   logic                nxt_halted;
   logic [ADDR_W-1:0]   nxt_hpc;
   logic                wr_en;
   logic                at_halt_addr;
   logic [PW-1:0]       rd_slot;
   logic                rd_in_range;

   assign state        = cur_st;
   assign at_halt_addr = (USE_HALT_ADDR != 0) && (pc == HALT_ADDR);
   assign rd_slot      = wptr - PW'(1) - rd_idx;
   assign rd_in_range  = ({1'b0, rd_idx} < trace_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur_st <= ST_IDLE;
      else        cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st     = cur_st;
      nxt_cnt    = cycle_cnt;
      nxt_tc     = trace_count;
      nxt_wptr   = wptr;
      nxt_prev   = prev_pc;
      nxt_stall  = stall_cnt;
      nxt_halted = halted;
      nxt_hpc    = halt_pc;
      wr_en      = 1'b0;
      if (clr) begin
         nxt_st     = ST_IDLE;
         nxt_cnt    = '0;
         nxt_tc     = '0;
         nxt_wptr   = '0;
         nxt_stall  = '0;
         nxt_halted = 1'b0;
         nxt_hpc    = '0;
      end else if (run_en) begin
         case (cur_st)
            ST_IDLE: begin
               wr_en     = 1'b1;
               nxt_wptr  = wptr + PW'(1);
               nxt_tc    = (PW+1)'(1);
               nxt_prev  = pc;
               nxt_stall = '0;
               nxt_cnt   = CNT_W'(1);
               nxt_st    = ST_RUN;
               if (at_halt_addr) begin
                  nxt_st     = ST_HALTED;
                  nxt_halted = 1'b1;
                  nxt_hpc    = pc;
               end
            end
            ST_RUN: begin
               if (cycle_cnt != '1) nxt_cnt = cycle_cnt + CNT_W'(1);
               if (pc != prev_pc) begin
                  wr_en     = 1'b1;
                  nxt_wptr  = wptr + PW'(1);
                  if (trace_count != (PW+1)'(DEPTH)) nxt_tc = trace_count + (PW+1)'(1);
                  nxt_prev  = pc;
                  nxt_stall = '0;
               end else begin
                  // stall_cnt counts repeats after the first sample of this PC
                  nxt_stall = stall_cnt + SW'(1);
                  if (nxt_stall == SW'(HALT_CYCLES - 1)) begin
                     nxt_st     = ST_HALTED;
                     nxt_halted = 1'b1;
                     nxt_hpc    = pc;
                  end
               end
               if (at_halt_addr) begin
                  nxt_st     = ST_HALTED;
                  nxt_halted = 1'b1;
                  nxt_hpc    = pc;
               end
            end
            ST_HALTED: ;
            default: nxt_st = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         trace_count <= '0;
         wptr        <= '0;
         prev_pc     <= '0;
         stall_cnt   <= '0;
         halted      <= 1'b0;
         halt_pc     <= '0;
         rd_data     <= '0;
         rd_hit      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) trace_mem[i] <= '0;
      end else begin
         cycle_cnt   <= nxt_cnt;
         trace_count <= nxt_tc;
         wptr        <= nxt_wptr;
         prev_pc     <= nxt_prev;
         stall_cnt   <= nxt_stall;
         halted      <= nxt_halted;
         halt_pc     <= nxt_hpc;
         // read samples the pre-write array, so a same-slot write shows up next cycle
         rd_hit      <= rd_in_range;
         rd_data     <= rd_in_range ? trace_mem[rd_slot] : '0;
         if (wr_en) trace_mem[wptr] <= pc;
      end
   end

endmodule

// File: tb/tb_pc_run_monitor.sv
// Directed bench for pc_run_monitor: default, small-wrap and halt-address instances.
module tb_pc_run_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // instance A: defaults
   logic [7:0]  a_pc = '0, a_rdd, a_hpc;
   logic        a_run = 0, a_clr = 0, a_hit, a_hlt;
   logic [3:0]  a_idx = '0;
   logic [4:0]  a_tc;
   logic [31:0] a_cc;
   logic [1:0]  a_st;

   // instance B: DEPTH=8, 4-bit counter
   logic [7:0]  b_pc = '0, b_rdd, b_hpc;
   logic        b_run = 0, b_clr = 0, b_hit, b_hlt;
   logic [2:0]  b_idx = '0;
   logic [3:0]  b_tc;
   logic [3:0]  b_cc;
   logic [1:0]  b_st;

   // instance C: halt address 0x10
   logic [7:0]  c_pc = '0, c_rdd, c_hpc;
   logic        c_run = 0, c_clr = 0, c_hit, c_hlt;
   logic [3:0]  c_idx = '0;
   logic [4:0]  c_tc;
   logic [31:0] c_cc;
   logic [1:0]  c_st;

   pc_run_monitor u_a (
      .clk(clk), .rst_n(rst_n), .pc(a_pc), .run_en(a_run), .clr(a_clr), .rd_idx(a_idx),
      .rd_data(a_rdd), .rd_hit(a_hit), .trace_count(a_tc), .cycle_cnt(a_cc),
      .halted(a_hlt), .halt_pc(a_hpc), .state(a_st));

   pc_run_monitor #(.DEPTH(8), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .pc(b_pc), .run_en(b_run), .clr(b_clr), .rd_idx(b_idx),
      .rd_data(b_rdd), .rd_hit(b_hit), .trace_count(b_tc), .cycle_cnt(b_cc),
      .halted(b_hlt), .halt_pc(b_hpc), .state(b_st));

   pc_run_monitor #(.USE_HALT_ADDR(1), .HALT_ADDR(8'h10)) u_c (
      .clk(clk), .rst_n(rst_n), .pc(c_pc), .run_en(c_run), .clr(c_clr), .rd_idx(c_idx),
      .rd_data(c_rdd), .rd_hit(c_hit), .trace_count(c_tc), .cycle_cnt(c_cc),
      .halted(c_hlt), .halt_pc(c_hpc), .state(c_st));

   typedef struct {
      int pc; int run; int clr; int idx;
      int st; int tc; int cc; int hlt; int hpc; int hit; int rdd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t v(int pc, int run, int clr, int idx, int st, int tc, int cc,
                              int hlt, int hpc, int hit, int rdd);
      vec_t r;
      r.pc = pc; r.run = run; r.clr = clr; r.idx = idx; r.st = st; r.tc = tc; r.cc = cc;
      r.hlt = hlt; r.hpc = hpc; r.hit = hit; r.rdd = rdd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input int st, input int tc, input int cc,
                        input int hlt, input int hpc, input int hit, input int rdd);
      chk({tag, ".state"},   32'(a_st),  32'(st));
      chk({tag, ".tcount"},  32'(a_tc),  32'(tc));
      chk({tag, ".cycles"},  a_cc,       32'(cc));
      chk({tag, ".halted"},  32'(a_hlt), 32'(hlt));
      chk({tag, ".halt_pc"}, 32'(a_hpc), 32'(hpc));
      chk({tag, ".rd_hit"},  32'(a_hit), 32'(hit));
      chk({tag, ".rd_data"}, 32'(a_rdd), 32'(rdd));
   endtask

   initial begin
      // A: linear run, reads, hold, clear, self-loop halt, frozen HALTED
      vq.push_back(v('h00,1,0,0,  1,1,1,0,0,   0,'h00));
      vq.push_back(v('h04,1,0,0,  1,2,2,0,0,   1,'h00));
      vq.push_back(v('h08,1,0,0,  1,3,3,0,0,   1,'h04));
      vq.push_back(v('h0C,1,0,0,  1,4,4,0,0,   1,'h08));
      vq.push_back(v('h10,1,0,0,  1,5,5,0,0,   1,'h0C));
      vq.push_back(v('h14,1,0,0,  1,6,6,0,0,   1,'h10));
      vq.push_back(v('h18,1,0,0,  1,7,7,0,0,   1,'h14));
      vq.push_back(v('h1C,1,0,0,  1,8,8,0,0,   1,'h18));
      vq.push_back(v('h1C,0,0,0,  1,8,8,0,0,   1,'h1C));
      vq.push_back(v('h1C,0,0,7,  1,8,8,0,0,   1,'h00));
      vq.push_back(v('h1C,0,0,8,  1,8,8,0,0,   0,'h00));
      vq.push_back(v('h55,0,0,15, 1,8,8,0,0,   0,'h00));
      vq.push_back(v('h00,1,1,0,  0,0,0,0,0,   1,'h1C));
      vq.push_back(v('h00,1,0,0,  1,1,1,0,0,   0,'h00));
      vq.push_back(v('h04,1,0,0,  1,2,2,0,0,   1,'h00));
      vq.push_back(v('h08,1,0,0,  1,3,3,0,0,   1,'h04));
      vq.push_back(v('h08,1,0,0,  1,3,4,0,0,   1,'h08));
      vq.push_back(v('h08,1,0,0,  1,3,5,0,0,   1,'h08));
      vq.push_back(v('h08,1,0,0,  2,3,6,1,'h08,1,'h08));
      vq.push_back(v('h30,1,0,0,  2,3,6,1,'h08,1,'h08));
      vq.push_back(v('h30,1,0,2,  2,3,6,1,'h08,1,'h00));
      vq.push_back(v('h30,1,0,3,  2,3,6,1,'h08,0,'h00));

      // reset state of all instances
      #100;
      chk_a("rst_a", 0, 0, 0, 0, 0, 0, 0);
      chk("rst_b.state", 32'(b_st), 0);   chk("rst_b.tcount", 32'(b_tc), 0);
      chk("rst_b.cycles", 32'(b_cc), 0);  chk("rst_b.halted", 32'(b_hlt), 0);
      chk("rst_c.state", 32'(c_st), 0);   chk("rst_c.tcount", 32'(c_tc), 0);
      chk("rst_c.cycles", c_cc, 0);       chk("rst_c.halt_pc", 32'(c_hpc), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         a_pc  = 8'(vq[i].pc);
         a_run = vq[i].run[0];
         a_clr = vq[i].clr[0];
         a_idx = 4'(vq[i].idx);
         tick();
         chk_a($sformatf("vec%0d", i), vq[i].st, vq[i].tc, vq[i].cc,
               vq[i].hlt, vq[i].hpc, vq[i].hit, vq[i].rdd);
      end
      a_run = 0;

      // B: wrap with same-slot read, then counter saturation
      b_run = 1; b_idx = 3'd7;
      for (int i = 0; i < 10; i++) begin
         b_pc = 8'(4 * i);
         tick();
      end
      chk("wrap.tcount", 32'(b_tc), 8);
      chk("wrap.cycles", 32'(b_cc), 10);
      chk("wrap.same_slot_old", 32'(b_rdd), 'h04);
      chk("wrap.same_slot_hit", 32'(b_hit), 1);
      b_run = 0; b_idx = 3'd0;
      tick();
      chk("wrap.newest", 32'(b_rdd), 'h24);
      b_idx = 3'd7;
      tick();
      chk("wrap.oldest", 32'(b_rdd), 'h08);
      chk("wrap.hold_cycles", 32'(b_cc), 10);
      b_run = 1;
      for (int i = 0; i < 5; i++) begin
         b_pc = 8'('h40 + 4 * i);
         tick();
      end
      chk("sat.cycles_at_max", 32'(b_cc), 15);
      b_pc = 8'h60;
      tick();
      chk("sat.cycles_no_wrap", 32'(b_cc), 15);
      chk("sat.tcount", 32'(b_tc), 8);
      chk("sat.state", 32'(b_st), 1);
      b_run = 0;

      // C: halt address, hold, clear, immediate halt from IDLE
      c_run = 1;
      for (int i = 0; i < 4; i++) begin
         c_pc = 8'(4 * i);
         tick();
      end
      chk("haddr.pre_state", 32'(c_st), 1);
      chk("haddr.pre_halted", 32'(c_hlt), 0);
      c_pc = 8'h10;
      tick();
      chk("haddr.state", 32'(c_st), 2);
      chk("haddr.halted", 32'(c_hlt), 1);
      chk("haddr.halt_pc", 32'(c_hpc), 'h10);
      chk("haddr.cycles", c_cc, 5);
      chk("haddr.tcount", 32'(c_tc), 5);
      c_run = 0;
      for (int i = 0; i < 5; i++) begin
         c_pc = 8'('h20 + 4 * i);
         tick();
      end
      chk("hold.cycles", c_cc, 5);
      chk("hold.tcount", 32'(c_tc), 5);
      chk("hold.halt_pc", 32'(c_hpc), 'h10);
      c_clr = 1;
      tick();
      c_clr = 0;
      chk("clr.state", 32'(c_st), 0);
      chk("clr.tcount", 32'(c_tc), 0);
      chk("clr.halted", 32'(c_hlt), 0);
      chk("clr.cycles", c_cc, 0);
      chk("clr.halt_pc", 32'(c_hpc), 0);
      c_run = 1; c_pc = 8'h10;
      tick();
      chk("idle_haddr.state", 32'(c_st), 2);
      chk("idle_haddr.cycles", c_cc, 1);
      chk("idle_haddr.tcount", 32'(c_tc), 1);
      chk("idle_haddr.halt_pc", 32'(c_hpc), 'h10);
      c_run = 0;

      // A: asynchronous reset in the middle of a run
      a_clr = 1;
      tick();
      a_clr = 0; a_run = 1; a_idx = 4'd0;
      for (int i = 0; i < 5; i++) begin
         a_pc = 8'(4 * i);
         tick();
      end
      chk_a("prerst", 1, 5, 5, 0, 0, 1, 'h0C);
      #4;
      rst_n = 1'b0;
      #1;
      chk_a("midrst", 0, 0, 0, 0, 0, 0, 0);
      tick();
      a_run = 0;
      rst_n = 1'b1;
      a_run = 1; a_pc = 8'h40;
      tick();
      chk_a("postrst", 1, 1, 1, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
